// File: rtl/dispctl_pkg.sv
// rtl/dispctl_pkg.sv - shared constants and helpers for the seven-segment scan controller
package dispctl_pkg;

    // All segments off (active-low outputs).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low hex glyphs, bit 0 = segment a .. bit 6 = segment g.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dispctl_scan_if.sv
// rtl/dispctl_scan_if.sv - user-side values and display pins of the scan controller
interface dispctl_scan_if #(
    parameter int NDIGITS  = 8,
    parameter int BRIGHT_W = 2
);
    logic [4*NDIGITS-1:0] d;
    logic [NDIGITS-1:0]   dpin;
    logic [NDIGITS-1:0]   blank;
    logic [NDIGITS-1:0]   blink;
    logic [BRIGHT_W-1:0]  bright;
    logic [6:0]           seg;
    logic                 dp;
    logic [NDIGITS-1:0]   an;
    logic                 frame;

    modport master (output d, dpin, blank, blink, bright, input seg, dp, an, frame);
    modport slave  (input d, dpin, blank, blink, bright, output seg, dp, an, frame);
endinterface

// File: rtl/dispctl_scan_seven_seg.sv
// rtl/dispctl_scan_seven_seg.sv - hex nibble to active-low seven-segment decoder
module seven_seg
    import dispctl_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/dispctl_scan.sv
// rtl/dispctl_scan.sv - PWM-dimmed, frame-snapshotted multiplexed seven-segment scanner (optional DISPCTL_BLINK_EN)
module dispctl_scan
    import dispctl_pkg::*;
#(
    parameter int NDIGITS      = 8,
    parameter int TICK_DIV     = 1000,
    parameter int BRIGHT_W     = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic         clk,
    input  logic         reset,
    dispctl_scan_if.slave bus
);

    localparam int IW = idx_width(NDIGITS);
    localparam int TW = idx_width(TICK_DIV);

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q;
    logic [BRIGHT_W-1:0]  pwm_q;
    logic [BRIGHT_W-1:0]  bright_s_q;
    logic [IW-1:0]        idx_q;
    logic [4*NDIGITS-1:0] d_s_q;
    logic [NDIGITS-1:0]   dpin_s_q;
    logic [NDIGITS-1:0]   blank_s_q;

    logic [NDIGITS-1:0]   an_q;
    logic [6:0]           seg_q;
    logic                 dp_q;
    logic                 frame_q;

    logic                 tick;
    logic                 slot_end;
    logic                 slot_start;
    logic                 snap;
    logic                 blink_dark;
    logic                 lit;
    logic [3:0]           digit_sel;
    logic [6:0]           seg_dec;

    // Sequencer: one idle cycle after reset opens the first slot, then free-running scan.
    always_comb begin
        state_d    = state_q;
        tick       = 1'b0;
        slot_end   = 1'b0;
        slot_start = 1'b0;
        snap       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d    = ST_SCAN;
                slot_start = 1'b1;
                snap       = 1'b1;
            end
            ST_SCAN: begin
                tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
                slot_end   = tick && (pwm_q == '1);
                slot_start = slot_end;
                snap       = slot_end && (idx_q == IW'(NDIGITS - 1));
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Tick divider, PWM counter (its natural wrap ends a slot) and digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            pwm_q      <= '0;
            idx_q      <= '0;
        end else if (state_q == ST_SCAN) begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            if (tick)     pwm_q <= pwm_q + 1'b1;
            if (slot_end) idx_q <= (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Frame shadows keep the displayed values tear-free; brightness is held per slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_s_q      <= '0;
            dpin_s_q   <= '0;
            blank_s_q  <= '0;
            bright_s_q <= '0;
        end else begin
            if (snap) begin
                d_s_q     <= bus.d;
                dpin_s_q  <= bus.dpin;
                blank_s_q <= bus.blank;
            end
            if (slot_start) bright_s_q <= bus.bright;
        end
    end

`ifdef DISPCTL_BLINK_EN
    localparam int FW = idx_width(BLINK_FRAMES);

    logic [FW-1:0]      blink_cnt_q;
    logic               blink_phase_q;
    logic [NDIGITS-1:0] blink_s_q;

    // Blink phase flips every BLINK_FRAMES frames; the startup frame is not counted as a wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blink_s_q     <= '0;
        end else if (snap) begin
            blink_s_q <= bus.blink;
            if (state_q == ST_SCAN) begin
                if (blink_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    assign blink_dark = blink_s_q[idx_q] & blink_phase_q;
`else
    logic blink_unused;
    assign blink_unused = ^bus.blink;
    assign blink_dark   = 1'b0;
`endif

    assign digit_sel = d_s_q[{idx_q, 2'b00} +: 4];
    assign lit       = (pwm_q < bright_s_q) && !blank_s_q[idx_q] && !blink_dark;

    seven_seg u_dec (
        .hex_i (digit_sel),
        .seg_o (seg_dec)
    );

    // Registered pin drive so an, seg and dp all switch on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            an_q    <= lit ? ~(NDIGITS'(1) << idx_q) : '1;
            seg_q   <= lit ? seg_dec : SEG_BLANK;
            dp_q    <= lit ? ~dpin_s_q[idx_q] : 1'b1;
            frame_q <= snap;
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.frame = frame_q;

endmodule
